// File: rtl/display_7seg_scan_pkg.sv
// Shared constants for the 4-digit 7-segment scanner:
// active-high gfedcba patterns, FSM encodings, digit count.
package display_7seg_scan_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-high gfedcba segment pattern.
// Non-BCD codes 10..15 show a dash.
module bcd_to_7seg
  import display_7seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_7seg_scan.sv
// 4-digit multiplexed 7-segment scanner with frame snapshot and anti-ghost blanking.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1.
module display_7seg_scan
  import display_7seg_scan_pkg::*;
#(
  parameter int CLK_DIV    = 1000,
  parameter int GHOST_CYC  = 50,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] unidade,
  input  logic [3:0] dezena,
  input  logic [3:0] centena,
  input  logic [3:0] milhar,
  input  logic [3:0] dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GH_LAST  = CW'(GHOST_CYC - 1);
  localparam logic       INV     = ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = {4{INV}};
  localparam logic [6:0] SEG_OFF = {7{INV}};

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [NDIG-1:0][3:0] dig_q, dig_d;
  logic [3:0] dps_q, dps_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [3:0] an_q, an_d;
  logic fd_q, fd_d;
  logic [6:0] seg_raw;
  logic lz_blank;

  bcd_to_7seg u_dec (
    .bcd_i (dig_q[idx_q]),
    .seg_o (seg_raw)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    unique case (idx_q)
      2'd3: lz_blank = (dig_q[3] == 4'd0) && !dps_q[3];
      2'd2: lz_blank = (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0)
                       && !dps_q[2];
      2'd1: lz_blank = (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0)
                       && (dig_q[1] == 4'd0) && !dps_q[1];
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // cnt is the cycle index inside the slot; S_LOAD is index 0 of digit 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    dps_d   = dps_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = INV;
    fd_d    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        dig_d   = {milhar, centena, dezena, unidade};
        dps_d   = dp_in;
        idx_d   = 2'd0;
        cnt_d   = CW'(1);
        state_d = (GHOST_CYC == 1) ? S_DRIVE : S_BLANK;
      end
      S_BLANK: begin
        if (enable) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == GH_LAST) state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (enable) begin
          if (!lz_blank) begin
            an_d[idx_q] = ~INV;
            seg_d       = seg_raw ^ SEG_OFF;
            dp_d        = dps_q[idx_q] ^ INV;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              fd_d    = 1'b1;
              state_d = S_LOAD;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_BLANK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      dig_q   <= '0;
      dps_q   <= 4'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= INV;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dps_q   <= dps_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan (CLK_DIV=4, GHOST_CYC=1);
// an active-high and an active-low instance run side by side.
module tb_display_7seg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] unidade, dezena, centena, milhar, dp_in;
  logic [6:0] seg, seg_al;
  logic       dp, dp_al;
  logic [3:0] an, an_al;
  logic       frame_done, frame_done_al;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  display_7seg_scan #(
    .CLK_DIV(4), .GHOST_CYC(1), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .unidade(unidade), .dezena(dezena),
    .centena(centena), .milhar(milhar),
    .dp_in(dp_in), .seg(seg), .dp(dp),
    .an(an), .frame_done(frame_done)
  );

  display_7seg_scan #(
    .CLK_DIV(4), .GHOST_CYC(1), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rst(rst), .enable(enable),
    .unidade(unidade), .dezena(dezena),
    .centena(centena), .milhar(milhar),
    .dp_in(dp_in), .seg(seg_al), .dp(dp_al),
    .an(an_al), .frame_done(frame_done_al)
  );

  function automatic logic [6:0] segtab(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [12:0] obs,
                       input logic [12:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: {an,seg,dp,fd} got %h expected %h",
                tag, obs, exp);
  endtask

  task automatic cyc(input string tag, input logic [3:0] an_e,
                     input logic [6:0] seg_e, input logic dp_e,
                     input logic fd_e);
    @(posedge clk);
    #1;
    check(tag, {an, seg, dp, frame_done},
          {an_e, seg_e, dp_e, fd_e});
    check({tag, "_al"}, {an_al, seg_al, dp_al, frame_done_al},
          {~an_e, ~seg_e, ~dp_e, fd_e});
  endtask

  // Frame cycles k0..k1: k%4==0 is the blank cycle, 1..3 drive digit k/4
  task automatic frame(input string tag, input int k0, input int k1,
                       input logic [15:0] dg, input logic [3:0] dps,
                       input logic [3:0] lit, input int chg_k,
                       input logic [15:0] nxt);
    int  s;
    bit  on;
    for (int k = k0; k <= k1; k++) begin
      s  = k / 4;
      on = (k % 4 != 0) && lit[s];
      if (k == chg_k) {milhar, centena, dezena, unidade} = nxt;
      cyc($sformatf("%s_k%0d", tag, k),
          on ? 4'(1 << s) : 4'h0,
          on ? segtab(dg[s*4 +: 4]) : 7'h00,
          on ? dps[s] : 1'b0,
          k == 15);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    {milhar, centena, dezena, unidade} = 16'h1234;
    dp_in  = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {an, seg, dp, frame_done}, 13'h0);
    check("reset_al", {an_al, seg_al, dp_al, frame_done_al},
          {4'hF, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;

    // inputs switch to 5678 inside digit 1's slot
    frame("f1234", 0, 15, 16'h1234, 4'b0100, 4'hF, 6, 16'h5678);
    frame("f5678", 0, 15, 16'h5678, 4'b0100, 4'hF, -1, 16'h0);

    {milhar, centena, dezena, unidade} = 16'h567A;
    frame("finv", 0, 15, 16'h567A, 4'b0100, 4'hF, -1, 16'h0);

    frame("fen", 0, 1, 16'h567A, 4'b0100, 4'hF, -1, 16'h0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc($sformatf("dis%0d", i), 4'h0, 7'h00, 1'b0, 1'b0);
    enable = 1'b1;
    frame("fen", 2, 15, 16'h567A, 4'b0100, 4'hF, -1, 16'h0);

    {milhar, centena, dezena, unidade} = 16'h0007;
    dp_in = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    frame("lz", 0, 15, 16'h0007, 4'b0000, 4'b0001, -1, 16'h0);
`else
    frame("lz", 0, 15, 16'h0007, 4'b0000, 4'b1111, -1, 16'h0);
`endif
    dp_in = 4'b0100;
`ifdef LEADING_ZERO_BLANK_EN
    frame("lzdp", 0, 15, 16'h0007, 4'b0100, 4'b0111, -1, 16'h0);
`else
    frame("lzdp", 0, 15, 16'h0007, 4'b0100, 4'b1111, -1, 16'h0);
`endif

    {milhar, centena, dezena, unidade} = 16'h1234;
    frame("prerst", 0, 9, 16'h1234, 4'b0100, 4'hF, -1, 16'h0);
    rst = 1'b1;
    cyc("midrst", 4'h0, 7'h00, 1'b0, 1'b0);
    rst = 1'b0;
    frame("postrst", 0, 15, 16'h1234, 4'b0100, 4'hF, -1, 16'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
